alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Multi-cycle R-type execute/writeback stage that sits directly downstream of the register file's read ports and upstream of its write port. It accepts one decoded R-type instruction at a time and drives the read-register addresses. It latches the returned operands, computes the result (single-cycle logic ops, iterative shifts, iterative 32×32 multiply) and issues exactly one write-back. The handshake stalls the instruction source while an operation is in flight.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- Clk  input  1  sole clock, rising edge.
- Reset  input  1  synchronous, active-high; sampled on rising Clk.
- InValid  input  1  instruction fields valid this cycle.
- InReady  output  1  unit can accept; high only in IDLE with Reset low.
- Funct3  input  3  R-type funct3.
- Funct7  input  7  R-type funct7.
- Rs1, Rs2, Rd  input  5 each  source/destination register indices.
- ReadReg1, ReadReg2  output  5 each  register-file read addresses; combinationally equal to Rs1/Rs2.
- ReadData1, ReadData2  input  XLEN each  asynchronous register-file read data.
- WriteReg  output  5  write-back index; registered.
- WriteData  output  XLEN  write-back data; registered.
- RegWrite  output  1  write strobe, one cycle per instruction; registered.
- Done  output  1  one-cycle pulse coincident with the write-back cycle; registered.
- Illegal  output  1  valid with Done; instruction encoding unsupported.

## Operation
- States: IDLE, SHIFT, MUL, WB.
- Accept: InValid && InReady. On accept, latch ReadData1→A, ReadData2→B, Rd, Funct3 and Funct7, then decode.
- Funct7=0000000 or 0100000: single-cycle ops.
  - 000: ADD, or SUB when Funct7[5]=1.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 110: OR.
  - 111: AND.
  - Result is registered on accept. Next state: WB.
- Funct3 001 (SLL) and 101 (SRL, or SRA when Funct7[5]=1):
  - Shift count = B[4:0].
  - Count 0: result = A, next state WB.
  - Otherwise: SHIFT state, shifting one bit per cycle and decrementing the count. SRA replicates bit 31. Go to WB when the count reaches 0.
- Funct7=0000001 with Funct3=000: MUL, low 32 bits of the product, signedness irrelevant.
  - MUL state runs 32 cycles, shift-add: each cycle, if B[0] then acc += A; then A <<= 1, B >>= 1.
  - A 5-bit counter controls exit.
- Any other Funct7, or Funct7=0000001 with Funct3≠000: Illegal.
  - Next state WB with RegWrite suppressed and Illegal=1.
- WB (one cycle):
  - RegWrite=1 unless Rd==0 or Illegal.
  - Done=1, WriteReg=Rd, WriteData=result.
  - Next state IDLE.
- All arithmetic is modulo 2^32; carries and overflow are discarded.

## Timing
- Reset values: state IDLE; RegWrite, Done, Illegal, WriteReg and WriteData all 0. InReady is 0 while Reset is high and 1 in the first cycle after Reset falls.
- Accept at cycle T.
  - Single-cycle op: WB at T+1, register file updated at the end of T+1, InReady high at T+2.
  - Shift by n>0: WB at T+n+1.
  - MUL: WB at T+33.
  - Illegal: WB at T+1.
- Back-to-back dependency is safe: the next accept occurs no earlier than T+2, so its operands reflect the prior write.
- InValid while busy: ignored. The source must hold its fields until accepted.
- Reset during SHIFT, MUL or WB: state returns to IDLE on that edge and the in-flight instruction is dropped. If Reset coincides with WB, RegWrite is 0 in the following cycle; the WB cycle itself is not retracted.
- Shift count is B[4:0] only; B[31:5] is ignored.

## Structure
- Shared package alu_exec_pkg holds:
  - funct3 and funct7 encoding constants;
  - the state encoding (2 bits);
  - the MUL iteration count constant (32).
- Sub-module alu_comb: purely combinational single-cycle ops (ADD/SUB/SLT/SLTU/XOR/OR/AND). The FSM, shifter, multiplier and handshake stay in alu_exec_unit.

## Test plan
- Reset held 2 cycles, then released → all outputs 0 during reset; InReady=1 on the first cycle after release.
- x5=10, x6=7, SUB rd=x7 → single RegWrite at T+1 with WriteReg=7, WriteData=3; InReady low for exactly one cycle.
- x2=0x80000000, x3=4, SRA rd=x4 → Done at T+5, WriteData=0xF8000000. Repeat with SRL → 0x08000000.
- x2=0xFFFFFFFF, x3=0xFFFFFFFF, MUL rd=x8 → Done at T+33, WriteData=0x00000001. Repeat with 5×13 → 65.
- ADD rd=x0 → Done=1, RegWrite=0. Funct7=0000001 with Funct3=100 → Illegal=1, RegWrite=0.
- Reset asserted at MUL cycle 10 → no RegWrite and no Done; next instruction accepted correctly after release.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared encodings for the R-type execute/writeback unit: funct fields,
// FSM state encoding and multiplier iteration count.
package alu_exec_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_MUL     = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_MUL   = 2'b10,
        ST_WB    = 2'b11
    } state_e;

    localparam int         MUL_ITERS    = 32;
    localparam logic [4:0] MUL_LAST_CNT = 5'(MUL_ITERS - 1);

endpackage

// File: rtl/alu_exec_unit_alu_comb.sv
// Purely combinational single-cycle R-type operations
// (ADD/SUB/SLT/SLTU/XOR/OR/AND); shift encodings yield zero here.
module alu_comb
    import alu_exec_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    input  logic            alt,
    output logic [XLEN-1:0] result
);

    // Select the single-cycle result by funct3; alt turns ADD into SUB
    always_comb begin
        result = {XLEN{1'b0}};
        case (funct3)
            F3_ADD_SUB: begin
                if (alt) begin
                    result = a - b;
                end else begin
                    result = a + b;
                end
            end
            F3_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            F3_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            F3_XOR:  result = a ^ b;
            F3_OR:   result = a | b;
            F3_AND:  result = a & b;
            default: result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle R-type execute/writeback stage: latches register-file operands,
// runs single-cycle, iterative shift or shift-add multiply, then one write-back.
module alu_exec_unit
    import alu_exec_pkg::*;
(
    input  logic            Clk,
    input  logic            Reset,
    input  logic            InValid,
    output logic            InReady,
    input  logic [2:0]      Funct3,
    input  logic [6:0]      Funct7,
    input  logic [4:0]      Rs1,
    input  logic [4:0]      Rs2,
    input  logic [4:0]      Rd,
    output logic [4:0]      ReadReg1,
    output logic [4:0]      ReadReg2,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    output logic [4:0]      WriteReg,
    output logic [XLEN-1:0] WriteData,
    output logic            RegWrite,
    output logic            Done,
    output logic            Illegal
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [4:0]      rd_q, rd_d;
    logic            shl_q, shl_d;
    logic            arith_q, arith_d;
    logic [4:0]      write_reg_q, write_reg_d;
    logic [XLEN-1:0] write_data_q, write_data_d;
    logic            reg_write_q, reg_write_d;
    logic            done_q, done_d;
    logic            illegal_q, illegal_d;

    logic            in_ready_s;
    logic            accept_s;
    logic            base_op_s;
    logic            is_shift_s;
    logic            is_mul_s;
    logic [XLEN-1:0] alu_result_s;
    logic [XLEN-1:0] shl_s;
    logic [XLEN-1:0] shr_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] mul_acc_s;
    logic            wb_fire_s;
    logic            wb_illegal_s;
    logic [4:0]      wb_rd_s;
    logic [XLEN-1:0] wb_data_s;

    assign ReadReg1   = Rs1;
    assign ReadReg2   = Rs2;
    assign in_ready_s = (state_q == ST_IDLE) && !Reset;
    assign InReady    = in_ready_s;
    assign accept_s   = InValid && in_ready_s;

    assign base_op_s  = (Funct7 == F7_BASE) || (Funct7 == F7_ALT);
    assign is_shift_s = base_op_s && ((Funct3 == F3_SLL) || (Funct3 == F3_SRL_SRA));
    assign is_mul_s   = (Funct7 == F7_MULDIV) && (Funct3 == F3_MUL);

    assign shl_s     = {a_q[XLEN-2:0], 1'b0};
    assign shr_s     = {arith_q & a_q[XLEN-1], a_q[XLEN-1:1]};
    assign mul_acc_s = acc_q + (b_q[0] ? a_q : {XLEN{1'b0}});

    assign WriteReg  = write_reg_q;
    assign WriteData = write_data_q;
    assign RegWrite  = reg_write_q;
    assign Done      = done_q;
    assign Illegal   = illegal_q;

    alu_comb u_alu_comb (
        .a      (ReadData1),
        .b      (ReadData2),
        .funct3 (Funct3),
        .alt    (Funct7[5]),
        .result (alu_result_s)
    );

    // Next-state, datapath iteration and write-back strobe generation
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        rd_d         = rd_q;
        shl_d        = shl_q;
        arith_d      = arith_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        done_d       = 1'b0;
        illegal_d    = 1'b0;
        wb_fire_s    = 1'b0;
        wb_illegal_s = 1'b0;
        wb_rd_s      = rd_q;
        wb_data_s    = {XLEN{1'b0}};
        shifted_s    = shl_q ? shl_s : shr_s;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    a_d     = ReadData1;
                    b_d     = ReadData2;
                    rd_d    = Rd;
                    shl_d   = (Funct3 == F3_SLL);
                    arith_d = Funct7[5];
                    wb_rd_s = Rd;
                    if (is_shift_s) begin
                        cnt_d = ReadData2[4:0];
                        if (ReadData2[4:0] == 5'd0) begin
                            wb_fire_s = 1'b1;
                            wb_data_s = ReadData1;
                        end else begin
                            state_d = ST_SHIFT;
                        end
                    end else if (base_op_s) begin
                        wb_fire_s = 1'b1;
                        wb_data_s = alu_result_s;
                    end else if (is_mul_s) begin
                        acc_d   = {XLEN{1'b0}};
                        cnt_d   = 5'd0;
                        state_d = ST_MUL;
                    end else begin
                        wb_fire_s    = 1'b1;
                        wb_illegal_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_d   = shifted_s;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    wb_fire_s = 1'b1;
                    wb_data_s = shifted_s;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_MUL: begin
                acc_d = mul_acc_s;
                a_d   = shl_s;
                b_d   = {1'b0, b_q[XLEN-1:1]};
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == MUL_LAST_CNT) begin
                    wb_fire_s = 1'b1;
                    wb_data_s = mul_acc_s;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered on entry to WB so they line up with that cycle
        if (wb_fire_s) begin
            state_d      = ST_WB;
            done_d       = 1'b1;
            illegal_d    = wb_illegal_s;
            reg_write_d  = !wb_illegal_s && (wb_rd_s != 5'd0);
            write_reg_d  = wb_rd_s;
            write_data_d = wb_data_s;
        end else begin
            done_d      = 1'b0;
            illegal_d   = 1'b0;
            reg_write_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            a_q          <= {XLEN{1'b0}};
            b_q          <= {XLEN{1'b0}};
            acc_q        <= {XLEN{1'b0}};
            cnt_q        <= 5'd0;
            rd_q         <= 5'd0;
            shl_q        <= 1'b0;
            arith_q      <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= {XLEN{1'b0}};
            reg_write_q  <= 1'b0;
            done_q       <= 1'b0;
            illegal_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            shl_q        <= shl_d;
            arith_q      <= arith_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
            done_q       <= done_d;
            illegal_q    <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized
// instructions checked against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        Clk = 1'b0;
    logic        Reset, InValid, InReady;
    logic [2:0]  Funct3;
    logic [6:0]  Funct7;
    logic [4:0]  Rs1, Rs2, Rd, ReadReg1, ReadReg2, WriteReg;
    logic [31:0] ReadData1, ReadData2, WriteData;
    logic        RegWrite, Done, Illegal;

    logic [31:0] rf     [32];
    logic [31:0] exp_rf [32];

    int total = 0;
    int bad   = 0;

    int          lat, low;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw, il, ra, pa;

    always #5 Clk = ~Clk;

    assign ReadData1 = rf[ReadReg1];
    assign ReadData2 = rf[ReadReg2];

    alu_exec_unit dut (
        .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Funct3(Funct3), .Funct7(Funct7), .Rs1(Rs1), .Rs2(Rs2), .Rd(Rd),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WriteReg(WriteReg), .WriteData(WriteData),
        .RegWrite(RegWrite), .Done(Done), .Illegal(Illegal)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
        if (r != 5'd0) begin
            rf[r]     = v;
            exp_rf[r] = v;
        end
    endtask

    // Reference semantics straight from the instruction definitions
    function automatic void ref_model(input logic [2:0] f3, input logic [6:0] f7,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic ill, output int cyc);
        res = 32'd0;
        ill = 1'b0;
        cyc = 1;
        if (f7 == 7'h00 || f7 == 7'h20) begin
            case (f3)
                3'd0: begin if (f7[5]) res = a - b; else res = a + b; end
                3'd1: begin res = a << b[4:0]; cyc = int'(b[4:0]) + 1; end
                3'd2: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: res = (a < b) ? 32'd1 : 32'd0;
                3'd4: res = a ^ b;
                3'd5: begin
                    if (f7[5]) res = $signed(a) >>> b[4:0];
                    else       res = a >> b[4:0];
                    cyc = int'(b[4:0]) + 1;
                end
                3'd6: res = a | b;
                default: res = a & b;
            endcase
        end else if (f7 == 7'h01 && f3 == 3'd0) begin
            res = a * b;
            cyc = 33;
        end else begin
            ill = 1'b1;
        end
    endfunction

    // Drive one instruction, wait for Done (bounded) and report what was observed
    task automatic issue(input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         output int o_lat, output int o_low, output logic [31:0] o_wd,
                         output logic [4:0] o_wr, output logic o_rw, output logic o_il,
                         output logic o_ready_after, output logic o_pulse_after);
        int guard;
        Funct3 = f3; Funct7 = f7; Rs1 = rs1; Rs2 = rs2; Rd = rd; InValid = 1'b1;
        guard = 0;
        while (InReady !== 1'b1 && guard < 100) begin
            step();
            guard++;
        end
        step();
        InValid = 1'b0;
        Rs1 = 5'($urandom); Rs2 = 5'($urandom); Rd = 5'($urandom);
        Funct3 = 3'($urandom); Funct7 = 7'($urandom);
        o_lat = 1;
        o_low = 0;
        while (1'b1) begin
            if (InReady !== 1'b1) o_low++;
            if (Done === 1'b1 || o_lat >= 64) break;
            step();
            o_lat++;
        end
        if (Done !== 1'b1) o_lat = -1;
        o_wd = WriteData; o_wr = WriteReg; o_rw = RegWrite; o_il = Illegal;
        if (RegWrite === 1'b1 && WriteReg != 5'd0) rf[WriteReg] = WriteData;
        step();
        o_ready_after = InReady;
        o_pulse_after = Done | RegWrite;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        total++; if (Done !== 1'b0 || RegWrite !== 1'b0 || Illegal !== 1'b0) begin bad++; $display("FAIL reset_strobes: got done=%b rw=%b ill=%b want 0 0 0", Done, RegWrite, Illegal); end
        total++; if (WriteReg !== 5'd0 || WriteData !== 32'd0) begin bad++; $display("FAIL reset_wb: got reg=%0d data=%h want 0 0", WriteReg, WriteData); end
        total++; if (InReady !== 1'b0) begin bad++; $display("FAIL reset_ready_low: got %b want 0", InReady); end
        Reset = 1'b0;
        #1;
        total++; if (InReady !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", InReady); end
    endtask

    task automatic test_sub();
        set_reg(5'd5, 32'd10);
        set_reg(5'd6, 32'd7);
        issue(3'd0, 7'h20, 5'd5, 5'd6, 5'd7, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (lat !== 1) begin bad++; $display("FAIL sub_latency: got %0d want 1", lat); end
        total++; if (wr !== 5'd7 || wd !== 32'd3) begin bad++; $display("FAIL sub_wb: got x%0d=%h want x7=00000003", wr, wd); end
        total++; if (rw !== 1'b1 || il !== 1'b0) begin bad++; $display("FAIL sub_strobe: got rw=%b ill=%b want 1 0", rw, il); end
        total++; if (low !== 1 || ra !== 1'b1) begin bad++; $display("FAIL sub_ready: got low=%0d after=%b want 1 1", low, ra); end
        total++; if (pa !== 1'b0) begin bad++; $display("FAIL sub_single_pulse: got %b want 0", pa); end
    endtask

    task automatic test_shifts();
        set_reg(5'd2, 32'h8000_0000);
        set_reg(5'd3, 32'd4);
        issue(3'd5, 7'h20, 5'd2, 5'd3, 5'd4, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (lat !== 5) begin bad++; $display("FAIL sra_latency: got %0d want 5", lat); end
        total++; if (wd !== 32'hF800_0000 || rw !== 1'b1) begin bad++; $display("FAIL sra_data: got %h rw=%b want f8000000 1", wd, rw); end
        issue(3'd5, 7'h00, 5'd2, 5'd3, 5'd4, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (lat !== 5 || wd !== 32'h0800_0000) begin bad++; $display("FAIL srl: got lat=%0d %h want 5 08000000", lat, wd); end
        set_reg(5'd11, 32'hFFFF_FFE0);
        issue(3'd1, 7'h00, 5'd2, 5'd11, 5'd12, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (lat !== 1 || wd !== 32'h8000_0000) begin bad++; $display("FAIL sll_zero_count: got lat=%0d %h want 1 80000000", lat, wd); end
        set_reg(5'd13, 32'd31);
        issue(3'd5, 7'h20, 5'd2, 5'd13, 5'd12, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (lat !== 32 || wd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sra_31: got lat=%0d %h want 32 ffffffff", lat, wd); end
    endtask

    task automatic test_mul();
        set_reg(5'd2, 32'hFFFF_FFFF);
        set_reg(5'd3, 32'hFFFF_FFFF);
        issue(3'd0, 7'h01, 5'd2, 5'd3, 5'd8, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (lat !== 33) begin bad++; $display("FAIL mul_latency: got %0d want 33", lat); end
        total++; if (wd !== 32'd1 || wr !== 5'd8 || rw !== 1'b1) begin bad++; $display("FAIL mul_neg1: got x%0d=%h rw=%b want x8=00000001 1", wr, wd, rw); end
        set_reg(5'd2, 32'd5);
        set_reg(5'd3, 32'd13);
        issue(3'd0, 7'h01, 5'd2, 5'd3, 5'd8, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (lat !== 33 || wd !== 32'd65) begin bad++; $display("FAIL mul_5x13: got lat=%0d %0d want 33 65", lat, wd); end
    endtask

    task automatic test_x0_illegal();
        issue(3'd0, 7'h00, 5'd2, 5'd3, 5'd0, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (lat !== 1 || rw !== 1'b0 || il !== 1'b0) begin bad++; $display("FAIL add_x0: got lat=%0d rw=%b ill=%b want 1 0 0", lat, rw, il); end
        issue(3'd4, 7'h01, 5'd2, 5'd3, 5'd9, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (lat !== 1 || il !== 1'b1 || rw !== 1'b0) begin bad++; $display("FAIL illegal_muldiv: got lat=%0d ill=%b rw=%b want 1 1 0", lat, il, rw); end
        issue(3'd0, 7'h7F, 5'd2, 5'd3, 5'd9, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (il !== 1'b1 || rw !== 1'b0 || pa !== 1'b0) begin bad++; $display("FAIL illegal_f7: got ill=%b rw=%b after=%b want 1 0 0", il, rw, pa); end
    endtask

    task automatic test_reset_mid_mul();
        int strobes;
        set_reg(5'd2, 32'd3);
        set_reg(5'd3, 32'd5);
        Funct3 = 3'd0; Funct7 = 7'h01; Rs1 = 5'd2; Rs2 = 5'd3; Rd = 5'd8; InValid = 1'b1;
        step();
        InValid = 1'b0;
        repeat (9) step();
        Reset = 1'b1;
        step();
        total++; if (InReady !== 1'b0 || Done !== 1'b0 || RegWrite !== 1'b0) begin bad++; $display("FAIL midmul_reset: got rdy=%b done=%b rw=%b want 0 0 0", InReady, Done, RegWrite); end
        Reset = 1'b0;
        #1;
        total++; if (InReady !== 1'b1) begin bad++; $display("FAIL midmul_ready: got %b want 1", InReady); end
        strobes = 0;
        for (int i = 0; i < 40; i++) begin
            if (Done === 1'b1 || RegWrite === 1'b1) strobes++;
            step();
        end
        total++; if (strobes !== 0) begin bad++; $display("FAIL midmul_dropped: got %0d strobes want 0", strobes); end
        issue(3'd0, 7'h01, 5'd2, 5'd3, 5'd8, lat, low, wd, wr, rw, il, ra, pa);
        total++; if (lat !== 33 || wd !== 32'd15 || rw !== 1'b1) begin bad++; $display("FAIL midmul_next: got lat=%0d %0d rw=%b want 33 15 1", lat, wd, rw); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, c, s;
        a = $urandom; b = $urandom; c = $urandom;
        set_reg(5'd1, a); set_reg(5'd2, b); set_reg(5'd3, c);
        issue(3'd0, 7'h00, 5'd1, 5'd2, 5'd9, lat, low, wd, wr, rw, il, ra, pa);
        s = a + b;
        total++; if (wd !== s) begin bad++; $display("FAIL b2b_add: got %h want %h", wd, s); end
        issue(3'd0, 7'h20, 5'd9, 5'd3, 5'd10, lat, low, wd, wr, rw, il, ra, pa);
        s = a + b - c;
        total++; if (wd !== s) begin bad++; $display("FAIL b2b_sub_dep: got %h want %h", wd, s); end
        issue(3'd0, 7'h01, 5'd10, 5'd10, 5'd11, lat, low, wd, wr, rw, il, ra, pa);
        s = s * s;
        total++; if (wd !== s) begin bad++; $display("FAIL b2b_mul_dep: got %h want %h", wd, s); end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  r1, r2, rd;
        logic [31:0] exp_res;
        logic        exp_ill, exp_rw;
        int          exp_lat;
        for (int i = 1; i < 32; i++) set_reg(5'(i), $urandom);
        for (int n = 0; n < 40; n++) begin
            f3 = 3'($urandom);
            case ($urandom_range(3, 0))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            r1 = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom);
            ref_model(f3, f7, exp_rf[r1], exp_rf[r2], exp_res, exp_ill, exp_lat);
            exp_rw = !exp_ill && (rd != 5'd0);
            issue(f3, f7, r1, r2, rd, lat, low, wd, wr, rw, il, ra, pa);
            total++; if (lat !== exp_lat || il !== exp_ill || rw !== exp_rw) begin bad++; $display("FAIL rand_ctrl[%0d] f3=%0d f7=%h: got lat=%0d ill=%b rw=%b want %0d %b %b", n, f3, f7, lat, il, rw, exp_lat, exp_ill, exp_rw); end
            if (!exp_ill) begin
                total++; if (wd !== exp_res || wr !== rd) begin bad++; $display("FAIL rand_data[%0d] f3=%0d f7=%h: got x%0d=%h want x%0d=%h", n, f3, f7, wr, wd, rd, exp_res); end
                if (rd != 5'd0) exp_rf[rd] = exp_res;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rf[i]     = 32'd0;
            exp_rf[i] = 32'd0;
        end
        Reset = 1'b1; InValid = 1'b0;
        Funct3 = 3'd0; Funct7 = 7'd0; Rs1 = 5'd0; Rs2 = 5'd0; Rd = 5'd0;
        test_reset();
        test_sub();
        test_shifts();
        test_mul();
        test_x0_illegal();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
